perf_trace_monitor: RTL and testbench
=====================================

PERF_TRACE_MONITOR -- requirements
Module: perf_trace_monitor

Interface
REQ-001 Parameter N_EV, default 4, number of generic event channels (1..16).
REQ-002 Parameter CNT_W, default 32, counter width (8..32).
REQ-003 Parameter TIMEOUT, default 100000, RUN cycle limit before forced stop.
REQ-004 Parameter FIFO_DEPTH, default 8, trace FIFO entries (power of two, >=2).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  pulse; IDLE->RUN.
REQ-008 clear  in  1  synchronous clear of counters, FIFO, flags; state->IDLE.
REQ-009 stall  in  1  global pipeline stall; masks all counting and trace capture.
REQ-010 hlt  in  1  halt retired this cycle.
REQ-011 ev_in  in  N_EV  per-channel event strobes (cache req/hit etc.).
REQ-012 commit_valid  in  1  architectural commit this cycle.
REQ-013 commit_type  in  2  0 REG, 1 LOAD, 2 STORE, 3 HALT.
REQ-014 commit_tag  in  16  register index (zero-extended) or memory address.
REQ-015 commit_data  in  16  write/load/store data.
REQ-016 rd_sel  in  5  counter select: 0 cycles, 1 instructions, 2+i ev[i].
REQ-017 rd_data  out  CNT_W  selected counter, registered.
REQ-018 tr_valid  out  1  trace FIFO non-empty.
REQ-019 tr_ready  in  1  consumer accepts head record.
REQ-020 tr_data  out  34  head record {type[1:0], tag[15:0], data[15:0]}.
REQ-021 state  out  2  0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT.
REQ-022 overflow  out  1  sticky: record dropped on full FIFO.

Function
REQ-023 "Live" = state==RUN and stall==0; only live cycles count events, commits or capture trace.
REQ-024 Cycle counter increments every RUN cycle regardless of stall.
REQ-025 Instruction counter increments on live commit_valid or live hlt (hlt alone counts once; hlt with commit_valid counts once).
REQ-026 ev counter i increments on live ev_in[i]; all channels independent, same cycle allowed.
REQ-027 All counters saturate at all-ones; no wrap.
REQ-028 IDLE: start -> RUN next cycle; other inputs ignored.
REQ-029 RUN: live hlt -> HALTED; else cycle count reaching TIMEOUT-1 this cycle -> TIMEOUT; hlt wins if both.
REQ-030 HALTED and TIMEOUT: counters frozen; exit only via clear or reset; start ignored.
REQ-031 clear has priority over start, hlt, timeout and push; FIFO, counters, overflow zeroed next cycle.
REQ-032 Push: live commit_valid writes {commit_type, commit_tag, commit_data}; live hlt without commit_valid writes {3, 0, 0}.
REQ-033 Pop: tr_valid & tr_ready removes head; tr_data shows head combinationally from storage, stable while tr_valid & ~tr_ready.
REQ-034 Full with push and no pop: record dropped, overflow set; full with push and pop same cycle: both succeed, no drop.
REQ-035 Empty with push and tr_ready: record not bypassed; tr_valid rises next cycle.
REQ-036 FIFO drains (pops honoured) in all states including HALTED/TIMEOUT.
REQ-037 rd_data = counter[rd_sel] sampled one cycle earlier; rd_sel >= N_EV+2 returns 0.

Reset
REQ-038 rst_n low asynchronously: state IDLE, all counters 0, FIFO empty, tr_valid 0, overflow 0, rd_data 0, tr_data 0.
REQ-039 Reset mid-RUN discards in-flight records and counts; operation resumes only after rst_n high and start.

Verification
REQ-040 start, 10 cycles with commit_valid=1 and stall=0, then hlt -> state HALTED, instructions 11, cycles 11, 11 records ending {3,0,0}.
REQ-041 start, stall=1 for 5 cycles with ev_in=all-ones and commit_valid=1 -> ev counters 0, instructions 0, cycles 5, FIFO empty.
REQ-042 tr_ready=0, 9 live commits with FIFO_DEPTH=8 -> 8 records retained in order, overflow=1; then tr_ready=1 with push each cycle when full -> no further drop.
REQ-043 TIMEOUT=20, start, no hlt -> state TIMEOUT after 20 RUN cycles, cycles=20, counters frozen thereafter; clear -> state IDLE, all counters 0.
REQ-044 CNT_W=8, ev_in[0] held 300 live cycles -> ev0 reads 255 via rd_sel=2 one cycle after select.
REQ-045 rst_n pulsed low mid-RUN with 3 records queued -> tr_valid 0, state IDLE, counters 0 without waiting for clk edge.

Source files
------------

// File: rtl/perf_trace_monitor.sv
// perf_trace_monitor: run-control FSM, saturating performance counters
// and a commit-trace FIFO with a sticky overflow flag.
module perf_trace_monitor #(
   parameter int N_EV       = 4,
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 100000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic             stall,
   input  logic             hlt,
   input  logic [N_EV-1:0]  ev_in,
   input  logic             commit_valid,
   input  logic [1:0]       commit_type,
   input  logic [15:0]      commit_tag,
   input  logic [15:0]      commit_data,
   input  logic [4:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic             tr_valid,
   input  logic             tr_ready,
   output logic [33:0]      tr_data,
   output logic [1:0]       state,
   output logic             overflow
);

   localparam int NCNT = N_EV + 2;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_V = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_TOUT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [NCNT];
   logic [CNT_W-1:0] cnt_d [NCNT];
   logic [CNT_W-1:0] rd_q, rd_d;
   logic [33:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]      fill_q, fill_d;
   logic             ovf_q, ovf_d;
   logic             live, push, pop, full, wr_en, drop;
   logic [33:0]      rec;
   logic [NCNT-1:0]  inc;
   logic [31:0]      cyc_ext;

   assign live    = (state_q == S_RUN) && !stall;
   assign cyc_ext = 32'(cnt_q[0]);

   assign tr_valid = (fill_q != '0);
   assign full     = (fill_q == FULL_V);
   assign pop      = tr_valid && tr_ready;
   assign push     = live && (commit_valid || hlt) && !clear;
   assign wr_en    = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign rec      = commit_valid ? {commit_type, commit_tag, commit_data}
                                  : {2'd3, 32'd0};

   assign tr_data  = tr_valid ? mem_q[rp_q] : '0;
   assign rd_data  = rd_q;
   assign state    = state_q;
   assign overflow = ovf_q;

   // run-control next state; clear overrides everything, halt beats timeout
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
               if (live && hlt) state_d = S_HALT;
               else if (cyc_ext >= 32'(TIMEOUT - 1)) state_d = S_TOUT;
            end
            default: ;
         endcase
      end
   end

   // per-counter increment strobes: 0 cycles, 1 instructions, 2+i events
   always_comb begin
      inc    = '0;
      inc[0] = (state_q == S_RUN);
      inc[1] = live && (commit_valid || hlt);
      for (int i = 0; i < N_EV; i++) inc[2+i] = live && ev_in[i];
   end

   // saturating counter update
   always_comb begin
      for (int i = 0; i < NCNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clear) cnt_d[i] = '0;
         else if (inc[i] && (cnt_q[i] != '1))
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
   end

   // counter readback mux; unmapped selects read as zero
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NCNT; i++)
         if (rd_sel == 5'(i)) rd_d = cnt_q[i];
   end

   // FIFO pointers, fill level and sticky overflow
   always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      fill_d = fill_q;
      ovf_d  = ovf_q;
      if (clear) begin
         wp_d   = '0;
         rp_d   = '0;
         fill_d = '0;
         ovf_d  = 1'b0;
      end else begin
         if (wr_en) wp_d = wp_q + AW'(1);
         if (pop)   rp_d = rp_q + AW'(1);
         if (wr_en && !pop) fill_d = fill_q + (AW+1)'(1);
         if (!wr_en && pop) fill_d = fill_q - (AW+1)'(1);
         if (drop) ovf_d = 1'b1;
      end
   end

   // state, counters, readback and FIFO control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rd_q    <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         fill_q  <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         fill_q  <= fill_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // trace record storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wp_q] <= rec;
      end
   end

endmodule

// File: tb/tb_perf_trace_monitor.sv
// tb_perf_trace_monitor: directed table plus hand sequences for
// counters, run control, trace FIFO and async reset.
module tb_perf_trace_monitor;

   localparam int N_EV = 4;
   localparam int NV   = 13;

   logic            clk, rst_n, start, clear, stall, hlt;
   logic [N_EV-1:0] ev_in;
   logic            commit_valid;
   logic [1:0]      commit_type;
   logic [15:0]     commit_tag, commit_data;
   logic [4:0]      rd_sel;
   logic [7:0]      rd_data;
   logic            tr_valid, tr_ready;
   logic [33:0]     tr_data;
   logic [1:0]      state;
   logic            overflow;
   logic [31:0]     rd_data2;
   logic            tr_valid2;
   logic [33:0]     tr_data2;
   logic [1:0]      state2;
   logic            overflow2;

   int              checks;
   int              errors;
   logic [33:0]     got_q[$];

   typedef struct {
      logic        start, clear, stall, hlt, cv, rdy;
      logic [1:0]  ctype;
      logic [15:0] tag, data;
      logic [4:0]  sel;
      logic        chk_rd;
      logic [7:0]  e_rd;
      logic [1:0]  e_st;
      logic        e_tv, e_ov;
      logic [33:0] e_td;
   } vec_t;

   vec_t tbl [NV];

   perf_trace_monitor #(
      .N_EV(N_EV), .CNT_W(8), .TIMEOUT(100000), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .stall(stall), .hlt(hlt), .ev_in(ev_in),
      .commit_valid(commit_valid), .commit_type(commit_type),
      .commit_tag(commit_tag), .commit_data(commit_data),
      .rd_sel(rd_sel), .rd_data(rd_data), .tr_valid(tr_valid),
      .tr_ready(tr_ready), .tr_data(tr_data), .state(state),
      .overflow(overflow)
   );

   perf_trace_monitor #(
      .N_EV(N_EV), .CNT_W(32), .TIMEOUT(20), .FIFO_DEPTH(8)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .stall(stall), .hlt(hlt), .ev_in(ev_in),
      .commit_valid(commit_valid), .commit_type(commit_type),
      .commit_tag(commit_tag), .commit_data(commit_data),
      .rd_sel(rd_sel), .rd_data(rd_data2), .tr_valid(tr_valid2),
      .tr_ready(tr_ready), .tr_data(tr_data2), .state(state2),
      .overflow(overflow2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [33:0] act,
                      input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      if (tr_valid && tr_ready) got_q.push_back(tr_data);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      start = 1'b0; clear = 1'b0; stall = 1'b0; hlt = 1'b0;
      ev_in = '0; commit_valid = 1'b0; commit_type = 2'd0;
      commit_tag = 16'h0; commit_data = 16'h0; tr_ready = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [4:0] sel,
                         input logic [7:0] exp);
      rd_sel = sel;
      tick();
      chk(name, 34'(rd_data), 34'(exp));
   endtask

   task automatic restart();
      idle();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      got_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      rd_sel = 5'd0;
      idle();

      tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,16'h0000,16'h0000,
                  5'd0,1'b0,8'd0,2'd0,1'b0,1'b0,34'h0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,16'h0055,16'h0000,
                  5'd0,1'b0,8'd0,2'd0,1'b0,1'b0,34'h0};
      tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'h0000,16'h0000,
                  5'd0,1'b0,8'd0,2'd1,1'b0,1'b0,34'h0};
      tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,16'h0011,16'h0022,
                  5'd0,1'b0,8'd0,2'd1,1'b0,1'b0,34'h0};
      tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,16'h0000,16'h0000,
                  5'd0,1'b0,8'd0,2'd1,1'b0,1'b0,34'h0};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'd1,16'h1234,16'habcd,
                  5'd0,1'b0,8'd0,2'd1,1'b1,1'b0,34'h1_1234_abcd};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,16'h0000,16'h0000,
                  5'd0,1'b0,8'd0,2'd1,1'b0,1'b0,34'h0};
      tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,16'h0000,16'h0000,
                  5'd0,1'b0,8'd0,2'd0,1'b0,1'b0,34'h0};
      tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'h0000,16'h0000,
                  5'd0,1'b0,8'd0,2'd1,1'b0,1'b0,34'h0};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,16'h0000,16'h0000,
                  5'd0,1'b0,8'd0,2'd2,1'b1,1'b0,34'h3_0000_0000};
      tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,16'h0000,16'h0000,
                  5'd0,1'b0,8'd0,2'd2,1'b1,1'b0,34'h3_0000_0000};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,16'h0000,16'h0000,
                  5'd1,1'b1,8'd1,2'd2,1'b0,1'b0,34'h0};
      tbl[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,16'h0000,16'h0000,
                  5'd0,1'b1,8'd1,2'd0,1'b0,1'b0,34'h0};

      // reset values
      #3;
      chk("rst_state", 34'(state), 34'(2'd0));
      chk("rst_tv", 34'(tr_valid), 34'(1'b0));
      chk("rst_ov", 34'(overflow), 34'(1'b0));
      chk("rst_rd", 34'(rd_data), 34'(8'd0));
      chk("rst_td", tr_data, 34'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < NV; i++) begin
         start        = tbl[i].start;
         clear        = tbl[i].clear;
         stall        = tbl[i].stall;
         hlt          = tbl[i].hlt;
         commit_valid = tbl[i].cv;
         tr_ready     = tbl[i].rdy;
         commit_type  = tbl[i].ctype;
         commit_tag   = tbl[i].tag;
         commit_data  = tbl[i].data;
         rd_sel       = tbl[i].sel;
         tick();
         chk($sformatf("vec%0d_state", i), 34'(state), 34'(tbl[i].e_st));
         chk($sformatf("vec%0d_tv", i), 34'(tr_valid), 34'(tbl[i].e_tv));
         chk($sformatf("vec%0d_ov", i), 34'(overflow), 34'(tbl[i].e_ov));
         chk($sformatf("vec%0d_td", i), tr_data, tbl[i].e_td);
         if (tbl[i].chk_rd)
            chk($sformatf("vec%0d_rd", i), 34'(rd_data), 34'(tbl[i].e_rd));
      end
      idle();

      // ten commits then halt, draining as we go
      restart();
      tr_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         commit_valid = 1'b1;
         commit_tag   = 16'(i);
         commit_data  = 16'(16'h0a00 + i);
         tick();
      end
      commit_valid = 1'b0;
      hlt = 1'b1;
      tick();
      hlt = 1'b0;
      chk("halt_state", 34'(state), 34'(2'd2));
      repeat (3) tick();
      chk("halt_nrec", 34'(got_q.size()), 34'(11));
      if (got_q.size() == 11) begin
         for (int i = 0; i < 10; i++)
            chk($sformatf("halt_rec%0d", i), got_q[i],
                {2'd0, 16'(i), 16'(16'h0a00 + i)});
         chk("halt_rec10", got_q[10], 34'h3_0000_0000);
      end
      tr_ready = 1'b0;
      rd_chk("halt_instr", 5'd1, 8'd11);
      rd_chk("halt_cycles", 5'd0, 8'd11);

      // independent event channels, hlt with commit counts once
      restart();
      ev_in = 4'b1011;
      repeat (2) tick();
      ev_in = 4'b0100;
      tick();
      ev_in = 4'b0000;
      commit_valid = 1'b1; commit_type = 2'd1;
      commit_tag = 16'h00aa; commit_data = 16'h5555; hlt = 1'b1;
      tick();
      commit_valid = 1'b0; hlt = 1'b0;
      chk("mix_state", 34'(state), 34'(2'd2));
      chk("mix_tv", 34'(tr_valid), 34'(1'b1));
      chk("mix_td", tr_data, {2'd1, 16'h00aa, 16'h5555});
      rd_chk("mix_instr", 5'd1, 8'd1);
      rd_chk("mix_cycles", 5'd0, 8'd4);
      rd_chk("mix_ev0", 5'd2, 8'd2);
      rd_chk("mix_ev1", 5'd3, 8'd2);
      rd_chk("mix_ev2", 5'd4, 8'd1);
      rd_chk("mix_ev3", 5'd5, 8'd2);
      rd_chk("mix_sel6", 5'd6, 8'd0);
      rd_chk("mix_sel31", 5'd31, 8'd0);

      // stall masks everything but the cycle counter
      restart();
      stall = 1'b1; ev_in = 4'hf; commit_valid = 1'b1;
      repeat (5) tick();
      ev_in = 4'h0; commit_valid = 1'b0;
      rd_chk("stall_cycles", 5'd0, 8'd5);
      rd_chk("stall_instr", 5'd1, 8'd0);
      for (int i = 0; i < N_EV; i++)
         rd_chk($sformatf("stall_ev%0d", i), 5'(2 + i), 8'd0);
      chk("stall_tv", 34'(tr_valid), 34'(1'b0));
      stall = 1'b0;

      // saturation at 8 bits
      restart();
      ev_in = 4'b0001;
      repeat (300) tick();
      ev_in = 4'b0000;
      rd_chk("sat_ev0", 5'd2, 8'd255);
      rd_chk("sat_cycles", 5'd0, 8'd255);
      rd_chk("sat_ev1", 5'd3, 8'd0);

      // overflow on full FIFO, then full push+pop without drop
      restart();
      for (int i = 0; i < 9; i++) begin
         commit_valid = 1'b1; commit_type = 2'd2;
         commit_tag = 16'(i); commit_data = 16'(16'h0100 + i);
         tick();
      end
      commit_valid = 1'b0;
      chk("ovf_flag", 34'(overflow), 34'(1'b1));
      chk("ovf_tv", 34'(tr_valid), 34'(1'b1));
      chk("ovf_head", tr_data, {2'd2, 16'h0000, 16'h0100});
      got_q.delete();
      tr_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         commit_valid = 1'b1; commit_type = 2'd2;
         commit_tag = 16'(16'h0020 + j); commit_data = 16'(16'h0200 + j);
         tick();
      end
      commit_valid = 1'b0;
      repeat (10) tick();
      chk("ovf_nrec", 34'(got_q.size()), 34'(12));
      if (got_q.size() == 12) begin
         for (int i = 0; i < 8; i++)
            chk($sformatf("ovf_rec%0d", i), got_q[i],
                {2'd2, 16'(i), 16'(16'h0100 + i)});
         for (int j = 0; j < 4; j++)
            chk($sformatf("ovf_rec%0d", 8 + j), got_q[8 + j],
                {2'd2, 16'(16'h0020 + j), 16'(16'h0200 + j)});
      end
      chk("ovf_sticky", 34'(overflow), 34'(1'b1));
      tr_ready = 1'b0;

      // timeout on the TIMEOUT=20 instance
      restart();
      repeat (19) tick();
      chk("to_run19", 34'(state2), 34'(2'd1));
      tick();
      chk("to_state", 34'(state2), 34'(2'd3));
      repeat (5) tick();
      rd_sel = 5'd0;
      tick();
      chk("to_cycles", 34'(rd_data2), 34'(32'd20));
      tick();
      chk("to_frozen", 34'(rd_data2), 34'(32'd20));
      chk("to_state2", 34'(state2), 34'(2'd3));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_state", 34'(state2), 34'(2'd0));
      chk("clr_ov", 34'(overflow), 34'(1'b0));
      tick();
      chk("clr_cycles", 34'(rd_data2), 34'(32'd0));
      rd_sel = 5'd1;
      tick();
      chk("clr_instr", 34'(rd_data2), 34'(32'd0));

      // asynchronous reset mid-run with queued records
      restart();
      rd_sel = 5'd0;
      for (int i = 0; i < 3; i++) begin
         commit_valid = 1'b1; commit_tag = 16'(i); commit_data = 16'(i);
         tick();
      end
      commit_valid = 1'b0;
      chk("ar_pre_tv", 34'(tr_valid), 34'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_tv", 34'(tr_valid), 34'(1'b0));
      chk("ar_state", 34'(state), 34'(2'd0));
      chk("ar_ov", 34'(overflow), 34'(1'b0));
      chk("ar_rd", 34'(rd_data), 34'(8'd0));
      chk("ar_td", tr_data, 34'h0);
      chk("ar_state2", 34'(state2), 34'(2'd0));
      #2;
      rst_n = 1'b1;
      tick();
      chk("ar_idle", 34'(state), 34'(2'd0));
      rd_chk("ar_instr", 5'd1, 8'd0);
      rd_chk("ar_cycles", 5'd0, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
